shift_reg_universal: RTL

- Parametrised universal shift register; successor to the fixed 4-bit serial-in/serial-out shifter.
- Supports serial shift in either direction, rotate, parallel load and hold.
- Exposes both serial and parallel outputs, plus a word-boundary pulse after every WIDTH serial shifts.
- Sits between bit-serial links and word-wide datapaths. Covers SISO, SIPO, PISO and PIPO use from one block.

---
 rtl/shift_reg_universal.sv | 112 +++++++++++
 1 files changed

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_universal
// Description : Parametrised universal shift register (shift/rotate/load/hold)
//               with serial and parallel outputs and a word-boundary pulse.
//               Optional word parity output enabled by SHIFT_REG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] par_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] par_out,
    output logic [WIDTH-1:0] word_out,
    output logic             word_done,
    output logic [CNT_W-1:0] bit_cnt
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    localparam logic [1:0]       c_mode_hold   = 2'b00;
    localparam logic [1:0]       c_mode_shift  = 2'b01;
    localparam logic [1:0]       c_mode_load   = 2'b10;
    localparam logic [1:0]       c_mode_rotate = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_last    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_word;
    logic             r_word_done;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] w_shift_val;
    logic [WIDTH-1:0] w_rot_val;
    logic             w_cnt_last;

    assign w_shift_val = dir ? {serial_in, r_reg[WIDTH-1:1]}
                             : {r_reg[WIDTH-2:0], serial_in};
    assign w_rot_val   = dir ? {r_reg[0], r_reg[WIDTH-1:1]}
                             : {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
    assign w_cnt_last  = (r_bit_cnt == c_cnt_last);

    // Exiting bit follows dir directly so a direction change is visible at once.
    assign serial_out = dir ? r_reg[0] : r_reg[WIDTH-1];
    assign par_out    = r_reg;
    assign word_out   = r_word;
    assign word_done  = r_word_done;
    assign bit_cnt    = r_bit_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg       <= '0;
            r_word      <= '0;
            r_word_done <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_word_done <= 1'b0;
            if (en) begin
                case (mode)
                    c_mode_hold: begin
                        r_reg <= r_reg;
                    end
                    c_mode_shift: begin
                        r_reg <= w_shift_val;
                        if (w_cnt_last) begin
                            r_bit_cnt   <= '0;
                            r_word      <= w_shift_val;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_cnt_one;
                        end
                    end
                    c_mode_load: begin
                        r_reg     <= par_in;
                        r_bit_cnt <= '0;
                    end
                    c_mode_rotate: begin
                        r_reg <= w_rot_val;
                    end
                    default: begin
                        r_reg <= r_reg;
                    end
                endcase
            end
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    logic r_word_parity;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word_parity <= 1'b0;
        end else if (en && (mode == c_mode_shift) && w_cnt_last) begin
            r_word_parity <= ^w_shift_val;
        end
    end

    assign word_parity = r_word_parity;
`endif

endmodule
`default_nettype wire
